// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and busy-register scoreboard for the 32x32 register file.
// Optional REGWB_ROUND_ROBIN_EN selects round-robin arbitration (default: LSU fixed priority).
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alu_valid,
    output logic               alu_ready,
    input  logic [AW-1:0]      alu_rd,
    input  logic [XLEN-1:0]    alu_data,
    input  logic               lsu_valid,
    output logic               lsu_ready,
    input  logic [AW-1:0]      lsu_rd,
    input  logic [XLEN-1:0]    lsu_data,
    input  logic               iss_valid,
    input  logic [AW-1:0]      iss_rd,
    input  logic               flush,
    input  logic [AW-1:0]      rs1,
    input  logic [AW-1:0]      rs2,
    output logic               rs1_busy,
    output logic               rs2_busy,
    output logic               rf_we,
    output logic [AW-1:0]      rf_wr,
    output logic [XLEN-1:0]    rf_wd,
    output logic [(1<<AW)-1:0] busy_mask
);

    localparam int NREG = 1 << AW;

    logic            grant_lsu;
    logic            grant_alu;
    logic            accept;
    logic [AW-1:0]   win_rd;
    logic [XLEN-1:0] win_data;
    logic [NREG-1:0] busy_next;

`ifdef REGWB_ROUND_ROBIN_EN
    // alu_pri=1 means the ALU wins the next contended cycle
    logic alu_pri;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_pri <= 1'b0;
        end else if (grant_lsu) begin
            alu_pri <= 1'b1;
        end else if (grant_alu) begin
            alu_pri <= 1'b0;
        end
    end

    always_comb begin
        grant_lsu = lsu_valid && (!alu_valid || !alu_pri);
        grant_alu = alu_valid && (!lsu_valid || alu_pri);
    end
`else
    always_comb begin
        grant_lsu = lsu_valid;
        grant_alu = alu_valid && !lsu_valid;
    end
`endif

    assign lsu_ready = grant_lsu && rst_n;
    assign alu_ready = grant_alu && rst_n;
    assign accept    = lsu_ready || alu_ready;
    assign win_rd    = grant_lsu ? lsu_rd : alu_rd;
    assign win_data  = grant_lsu ? lsu_data : alu_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we <= 1'b0;
            rf_wr <= '0;
            rf_wd <= '0;
        end else if (accept) begin
            rf_we <= (win_rd != '0);
            rf_wr <= win_rd;
            rf_wd <= win_data;
        end else begin
            rf_we <= 1'b0;
        end
    end

    // Issue set is applied after the write-back clear so a re-issued register stays busy
    always_comb begin
        busy_next = busy_mask;
        if (rf_we) begin
            busy_next[rf_wr] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            busy_next[iss_rd] = 1'b1;
        end
        if (flush) begin
            busy_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_mask <= '0;
        end else begin
            busy_mask <= busy_next;
        end
    end

    assign rs1_busy = busy_mask[rs1];
    assign rs2_busy = busy_mask[rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes queued by stimulus, checked by a monitor.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, lsu_valid, iss_valid, flush;
    logic        alu_ready, lsu_ready;
    logic [4:0]  alu_rd, lsu_rd, iss_rd, rs1, rs2, rf_wr;
    logic [31:0] alu_data, lsu_data, rf_wd, busy_mask;
    logic        rs1_busy, rs2_busy, rf_we;

    int n_chk  = 0;
    int n_fail = 0;

    logic [36:0] exp_q[$];
    logic [36:0] exp_w;
    logic [31:0] rf_model [32];

`ifdef REGWB_ROUND_ROBIN_EN
    bit exp_lsu [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    bit exp_lsu [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

    regfile_wb_arbiter #(.XLEN(32), .AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_we(rf_we), .rf_wr(rf_wr), .rf_wd(rf_wd), .busy_mask(busy_mask)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_we) rf_model[rf_wr] <= rf_wd;
    end

    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rf_write: got wr=%0d wd=%h, required no write", rf_wr, rf_wd);
            end else begin
                exp_w = exp_q.pop_front();
                if ({rf_wr, rf_wd} !== exp_w) begin
                    n_fail++;
                    $display("FAIL rf_write: got wr=%0d wd=%h, required wr=%0d wd=%h",
                             rf_wr, rf_wd, exp_w[36:32], exp_w[31:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        alu_valid = 1'b1; lsu_valid = 1'b1; iss_valid = 1'b0; flush = 1'b0;
        alu_rd = 5'd1; lsu_rd = 5'd2; iss_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        alu_data = 32'h0; lsu_data = 32'h0;
        #3;
        chk("reset_rf_we", rf_we, 0);
        chk("reset_rf_wr", rf_wr, 0);
        chk("reset_rf_wd", rf_wd, 0);
        chk("reset_busy", busy_mask, 0);
        chk("reset_alu_ready", alu_ready, 0);
        chk("reset_lsu_ready", lsu_ready, 0);
        alu_valid = 1'b0; lsu_valid = 1'b0;
        #20 rst_n = 1'b1;

        // ALU-only write to x10
        tick(); iss_valid = 1'b1; iss_rd = 5'd10; rs1 = 5'd10;
        #3 chk("alu1_busy_pre", busy_mask, 0);
        tick(); iss_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hdeadbeef;
        exp_q.push_back({5'd10, 32'hdeadbeef});
        #3 chk("alu1_ready", alu_ready, 1);
        chk("alu1_lsu_ready", lsu_ready, 0);
        chk("alu1_busy_set", busy_mask, 32'h0000_0400);
        chk("alu1_rs1_busy", rs1_busy, 1);
        tick(); alu_valid = 1'b0;
        #3 chk("alu1_rf_we", rf_we, 1);
        chk("alu1_busy_hold", busy_mask[10], 1);
        tick();
        #3 chk("alu1_busy_clr", busy_mask, 0);
        chk("alu1_rs1_free", rs1_busy, 0);
        chk("alu1_rf_read", rf_model[10], 32'hdeadbeef);

        // contention: LSU first, ALU next
        tick(); lsu_valid = 1'b1; lsu_rd = 5'd5; lsu_data = 32'hcafef00d;
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h12345678;
        exp_q.push_back({5'd5, 32'hcafef00d});
        exp_q.push_back({5'd6, 32'h12345678});
        #3 chk("cont_lsu_ready", lsu_ready, 1);
        chk("cont_alu_wait", alu_ready, 0);
        tick(); lsu_valid = 1'b0;
        #3 chk("cont_alu_ready", alu_ready, 1);
        chk("cont_lsu_idle", lsu_ready, 0);
        chk("cont_we1", rf_we, 1);
        tick(); alu_valid = 1'b0;
        #3 chk("cont_we2", rf_we, 1);
        tick();
        #3 chk("cont_we_off", rf_we, 0);

        // write to x0 and issue of x0
        tick(); alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h12345678;
        iss_valid = 1'b1; iss_rd = 5'd0;
        #3 chk("x0_ready", alu_ready, 1);
        tick(); alu_valid = 1'b0; iss_valid = 1'b0;
        #3 chk("x0_we", rf_we, 0);
        chk("x0_busy", busy_mask, 0);
        tick();
        #3 chk("x0_we_late", rf_we, 0);

        // same-edge clear and set of x20
        tick(); iss_valid = 1'b1; iss_rd = 5'd20; rs2 = 5'd20;
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h00000014;
        exp_q.push_back({5'd20, 32'h00000014});
        #3 chk("coll_ready", alu_ready, 1);
        tick(); alu_valid = 1'b0;
        #3 chk("coll_we", rf_we, 1);
        chk("coll_busy_pre", busy_mask, 32'h0010_0000);
        tick(); iss_valid = 1'b0;
        #3 chk("coll_busy_post", busy_mask, 32'h0010_0000);
        chk("coll_rs2_busy", rs2_busy, 1);

        // flush with busy regs and writes in flight
        tick(); iss_valid = 1'b1; iss_rd = 5'd3;
        tick(); iss_rd = 5'd7;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33333333;
        exp_q.push_back({5'd3, 32'h33333333});
        #3 chk("fl_ready1", alu_ready, 1);
        chk("fl_busy_a", busy_mask, 32'h0010_0008);
        tick(); flush = 1'b1; iss_rd = 5'd9;
        alu_rd = 5'd11; alu_data = 32'h0b0b0b0b;
        exp_q.push_back({5'd11, 32'h0b0b0b0b});
        #3 chk("fl_we_inflight", rf_we, 1);
        chk("fl_ready2", alu_ready, 1);
        chk("fl_busy_b", busy_mask, 32'h0010_0088);
        tick(); flush = 1'b0; iss_valid = 1'b0; alu_valid = 1'b0;
        #3 chk("fl_busy_zero", busy_mask, 0);
        chk("fl_we_after", rf_we, 1);
        tick();
        #3 chk("fl_we_off", rf_we, 0);

        // sustained contention for four cycles
        tick(); alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h20000000;
        lsu_valid = 1'b1; lsu_rd = 5'd13; lsu_data = 32'h10000000;
        for (int i = 0; i < 4; i++) begin
            #3 chk("series_lsu_ready", lsu_ready, exp_lsu[i]);
            chk("series_alu_ready", alu_ready, !exp_lsu[i]);
            if (exp_lsu[i]) exp_q.push_back({lsu_rd, lsu_data});
            else            exp_q.push_back({alu_rd, alu_data});
            tick();
            if (i < 3) begin
                if (exp_lsu[i]) lsu_data = lsu_data + 32'd1;
                else            alu_data = alu_data + 32'd1;
            end else begin
                if (exp_lsu[i]) lsu_valid = 1'b0;
                else            alu_valid = 1'b0;
            end
        end
        #3 chk("series_drain_alu", alu_ready, exp_lsu[3]);
        chk("series_drain_lsu", lsu_ready, !exp_lsu[3]);
        if (exp_lsu[3]) exp_q.push_back({alu_rd, alu_data});
        else            exp_q.push_back({lsu_rd, lsu_data});
        tick(); alu_valid = 1'b0; lsu_valid = 1'b0;
        tick();
        tick();

        // asynchronous reset while a write is pending
        iss_valid = 1'b1; iss_rd = 5'd8;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44444444;
        exp_q.push_back({5'd4, 32'h44444444});
        #3 chk("rst_pre_ready", alu_ready, 1);
        tick(); iss_valid = 1'b0; alu_valid = 1'b0;
        #1 chk("rst_pre_we", rf_we, 1);
        chk("rst_pre_busy", busy_mask, 32'h0000_0100);
        alu_valid = 1'b1;
        rst_n = 1'b0;
        #1 chk("rst_async_we", rf_we, 0);
        chk("rst_async_busy", busy_mask, 0);
        chk("rst_async_ready", alu_ready, 0);
        exp_q.delete();
        alu_valid = 1'b0;
        #10 rst_n = 1'b1;
        tick();
        tick();
        #3 chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
